// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative binary-to-BCD converter (shift-and-add-3) for on-screen numeric
// fields. A start captures the binary value, IN_W shift cycles build the BCD
// digits, and one final cycle registers the result, the leading-zero blank
// mask and the overflow flag.
//
// Parameters
//   IN_W     : width of the binary input (>= 1)
//   DIGITS   : number of BCD output digits (>= 1)
//   BLANK_LZ : 1 = generate leading-zero blank mask, 0 = mask forced to zero
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   gates acceptance of newframe
//   newframe    in   start strobe, sampled every edge while idle
//   some_value  in   [IN_W-1:0] unsigned value captured on an accepted start
//   exit_value  out  [4*DIGITS-1:0] BCD result, digit 0 (units) in [3:0]
//   digit_blank out  [DIGITS-1:0] bit i set: digit i is a leading zero
//   overflow    out  last converted value did not fit in DIGITS digits
//   busy        out  conversion in progress
//   done        out  one-cycle pulse when the outputs update
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int IN_W     = 10,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  newframe,
   input  logic [IN_W-1:0]       some_value,
   output logic [4*DIGITS-1:0]   exit_value,
   output logic [DIGITS-1:0]     digit_blank,
   output logic                  overflow,
   output logic                  busy,
   output logic                  done
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   // Idle mask: every digit except the units digit is shown blank.
   localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

   logic [1:0]       state;
   logic [IN_W-1:0]  shreg;
   logic [BCD_W-1:0] scratch;
   logic [CNT_W-1:0] cnt;
   logic             sticky;

   logic [BCD_W-1:0]  adj;
   logic [BCD_W-1:0]  nines;
   logic [DIGITS-1:0] blank_next;
   logic              zero_above;

   // Add-3 correction, saturation pattern and blank mask for the current
   // scratch contents.
   // NOTE: every combinational output is given a default before the loops so
   // no path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      adj        = scratch;
      nines      = '0;
      blank_next = '0;
      zero_above = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         nines[4*i +: 4] = 4'd9;
         // Digits are corrected independently; the +3 never carries across.
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      // Walk from the most significant digit down: a digit is blank when it
      // and every digit above it is zero. Units digit and overflow never blank.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (scratch[4*i +: 4] == 4'd0);
         if (i > 0 && BLANK_LZ != 0 && !sticky)
            blank_next[i] = zero_above;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   // NOTE: all datapath registers are reset as well as the FSM, so an aborted
   // conversion cannot leak stale scratch or sticky state into the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         shreg       <= '0;
         scratch     <= '0;
         cnt         <= '0;
         sticky      <= 1'b0;
         exit_value  <= '0;
         digit_blank <= BLANK_RST;
         overflow    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en && newframe) begin
                  shreg   <= some_value;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  cnt     <= CNT_W'(IN_W);
                  busy    <= 1'b1;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // {scratch, shreg} shifts left after correction; the bit leaving
               // the top digit means the value no longer fits.
               scratch <= {adj[BCD_W-2:0], shreg[IN_W-1]};
               shreg   <= shreg << 1;
               sticky  <= sticky | adj[BCD_W-1];
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= S_FINISH;
            end
            S_FINISH: begin
               overflow    <= sticky;
               exit_value  <= sticky ? nines : scratch;
               digit_blank <= blank_next;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. Three instances: default parameters,
// a wide one (IN_W=16, DIGITS=5) and one with blanking disabled. Expected
// values come from a decimal reference model using plain division.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   localparam int LAT_A = 11;   // done index for IN_W=10 (IN_W+1)
   localparam int LAT_W = 17;   // done index for IN_W=16

   logic clk = 1'b0;
   logic rst;

   logic        en_a, nf_a;
   logic [9:0]  val_a;
   logic [11:0] ex_a;
   logic [2:0]  bl_a;
   logic        ov_a, busy_a, done_a;

   logic        en_w, nf_w;
   logic [15:0] val_w;
   logic [19:0] ex_w;
   logic [4:0]  bl_w;
   logic        ov_w, busy_w, done_w;

   logic        en_n, nf_n;
   logic [9:0]  val_n;
   logic [11:0] ex_n;
   logic [2:0]  bl_n;
   logic        ov_n, busy_n, done_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.IN_W(10), .DIGITS(3), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .newframe(nf_a), .some_value(val_a),
      .exit_value(ex_a), .digit_blank(bl_a), .overflow(ov_a),
      .busy(busy_a), .done(done_a));

   bin_to_bcd_seq #(.IN_W(16), .DIGITS(5), .BLANK_LZ(1)) dut_w (
      .clk(clk), .rst(rst), .en(en_w), .newframe(nf_w), .some_value(val_w),
      .exit_value(ex_w), .digit_blank(bl_w), .overflow(ov_w),
      .busy(busy_w), .done(done_w));

   bin_to_bcd_seq #(.IN_W(10), .DIGITS(3), .BLANK_LZ(0)) dut_n (
      .clk(clk), .rst(rst), .en(en_n), .newframe(nf_n), .some_value(val_n),
      .exit_value(ex_n), .digit_blank(bl_n), .overflow(ov_n),
      .busy(busy_n), .done(done_n));

   // Decimal reference: saturate to 10^nd-1 on overflow, digits by mod/div,
   // digit i blank when the shown number is below 10^i.
   function automatic void model(input longint v, input int nd, input bit blz,
                                 output logic [19:0] bcd, output logic [4:0] blank,
                                 output bit ovf);
      longint lim = 1;
      longint r;
      longint p = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      ovf   = (v >= lim);
      r     = ovf ? lim - 1 : v;
      bcd   = '0;
      blank = '0;
      for (int i = 0; i < nd; i++) begin
         bcd[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      r = ovf ? lim - 1 : v;
      for (int i = 1; i < nd; i++) begin
         p = p * 10;
         if (blz && !ovf && r < p) blank[i] = 1'b1;
      end
   endfunction

   // Run one conversion on the default instance and verify timing and result.
   task automatic convert_a(input logic [9:0] v, input bit drop_en, input bit scramble);
      logic [19:0] e_bcd;
      logic [4:0]  e_bl;
      bit          e_ov;
      int          d_idx, b_cnt, d_cnt;
      model(longint'(v), 3, 1'b1, e_bcd, e_bl, e_ov);
      @(negedge clk);
      en_a = 1'b1; nf_a = 1'b1; val_a = v;
      @(negedge clk);
      nf_a = 1'b0;
      if (drop_en) en_a = 1'b0;
      if (scramble) val_a = 10'($urandom);
      d_idx = -1; b_cnt = 0; d_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         b_cnt += int'(busy_a);
         if (done_a) begin
            d_cnt++;
            if (d_idx < 0) d_idx = k;
         end
      end
      en_a = 1'b1;
      checks++;
      if (d_idx !== LAT_A || d_cnt !== 1) begin
         errors++;
         $display("FAIL conv_done v=%0d: idx %0d cnt %0d, want idx %0d cnt 1", v, d_idx, d_cnt, LAT_A);
      end
      checks++;
      if (b_cnt !== LAT_A) begin
         errors++;
         $display("FAIL conv_busy v=%0d: busy cycles %0d, want %0d", v, b_cnt, LAT_A);
      end
      checks++;
      if ({ex_a, bl_a, ov_a} !== {e_bcd[11:0], e_bl[2:0], e_ov}) begin
         errors++;
         $display("FAIL conv_result v=%0d: got %h/%b/%b, want %h/%b/%b",
                  v, ex_a, bl_a, ov_a, e_bcd[11:0], e_bl[2:0], e_ov);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({ex_a, bl_a, ov_a, busy_a, done_a} !== {12'h000, 3'b110, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_a: got %h/%b/%b/%b/%b, want 000/110/0/0/0", ex_a, bl_a, ov_a, busy_a, done_a);
      end
      checks++;
      if ({ex_w, bl_w, busy_w} !== {20'h00000, 5'b11110, 1'b0}) begin
         errors++;
         $display("FAIL reset_w: got %h/%b/%b, want 00000/11110/0", ex_w, bl_w, busy_w);
      end
      checks++;
      if (bl_n !== 3'b000) begin
         errors++;
         $display("FAIL reset_n_blank: got %b, want 000", bl_n);
      end
   endtask

   task automatic test_directed();
      logic [9:0] vals [8] = '{10'd0, 10'd255, 10'd7, 10'd40, 10'd999, 10'd1000, 10'd1023, 10'd5};
      foreach (vals[i]) convert_a(vals[i], 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++)
         convert_a(10'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // newframe pulses while busy must be dropped, not queued.
   task automatic test_ignore_busy();
      int d_cnt = 0;
      @(negedge clk);
      en_a = 1'b1; nf_a = 1'b1; val_a = 10'd123;
      @(negedge clk);
      nf_a = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         if (done_a) d_cnt++;
         nf_a = (k == 3 || k == 10);
         if (k == 3 || k == 10) val_a = 10'd456;
      end
      nf_a = 1'b0;
      checks++;
      if (d_cnt !== 1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL ignore_busy: done count %0d busy %b, want 1 and 0", d_cnt, busy_a);
      end
      checks++;
      if (ex_a !== 12'h123) begin
         errors++;
         $display("FAIL ignore_busy_value: got %h, want 123", ex_a);
      end
   endtask

   // With en low a start strobe is ignored and the last result holds (123).
   task automatic test_enable_low();
      int b_cnt = 0;
      int d_cnt = 0;
      @(negedge clk);
      en_a = 1'b0; nf_a = 1'b1; val_a = 10'd500;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         b_cnt += int'(busy_a);
         d_cnt += int'(done_a);
      end
      nf_a = 1'b0; en_a = 1'b1;
      checks++;
      if (b_cnt !== 0 || d_cnt !== 0 || ex_a !== 12'h123) begin
         errors++;
         $display("FAIL enable_low: busy %0d done %0d value %h, want 0 0 123", b_cnt, d_cnt, ex_a);
      end
   endtask

   // newframe held high: second start lands one edge after done.
   task automatic test_back_to_back();
      int d1 = -1;
      int d2 = -1;
      logic [11:0] r1 = '0;
      logic [11:0] r2 = '0;
      @(negedge clk);
      en_a = 1'b1; nf_a = 1'b1; val_a = 10'd321;
      @(negedge clk);
      val_a = 10'd654;
      for (int k = 0; k < 30; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 12) nf_a = 1'b0;
         if (done_a) begin
            if (d1 < 0) begin d1 = k; r1 = ex_a; end
            else if (d2 < 0) begin d2 = k; r2 = ex_a; end
         end
      end
      checks++;
      if (d1 !== LAT_A || d2 !== 2*LAT_A + 1) begin
         errors++;
         $display("FAIL b2b_timing: done at %0d,%0d, want %0d,%0d", d1, d2, LAT_A, 2*LAT_A + 1);
      end
      checks++;
      if (r1 !== 12'h321 || r2 !== 12'h654) begin
         errors++;
         $display("FAIL b2b_values: got %h,%h, want 321,654", r1, r2);
      end
   endtask

   task automatic test_reset_mid();
      int d_cnt = 0;
      convert_a(10'd255, 1'b0, 1'b0);
      @(negedge clk);
      en_a = 1'b1; nf_a = 1'b1; val_a = 10'd999;
      @(negedge clk);
      nf_a = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ex_a, bl_a, ov_a, busy_a, done_a} !== {12'h000, 3'b110, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got %h/%b/%b/%b/%b, want 000/110/0/0/0", ex_a, bl_a, ov_a, busy_a, done_a);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         d_cnt += int'(done_a) + int'(busy_a);
      end
      checks++;
      if (d_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_nodone: done/busy cycles %0d, want 0", d_cnt);
      end
   endtask

   task automatic test_wide();
      logic [15:0] vals [6];
      logic [19:0] e_bcd;
      logic [4:0]  e_bl;
      bit          e_ov;
      int          d_idx;
      vals = '{16'd65535, 16'd0, 16'd9, 16'd10000, 16'($urandom), 16'($urandom)};
      foreach (vals[i]) begin
         model(longint'(vals[i]), 5, 1'b1, e_bcd, e_bl, e_ov);
         @(negedge clk);
         en_w = 1'b1; nf_w = 1'b1; val_w = vals[i];
         @(negedge clk);
         nf_w = 1'b0;
         d_idx = -1;
         for (int k = 0; k < 22; k++) begin
            if (k > 0) @(negedge clk);
            if (done_w && d_idx < 0) d_idx = k;
         end
         checks++;
         if (d_idx !== LAT_W || {ex_w, bl_w, ov_w} !== {e_bcd, e_bl, e_ov}) begin
            errors++;
            $display("FAIL wide v=%0d: idx %0d got %h/%b/%b, want idx %0d %h/%b/%b",
                     vals[i], d_idx, ex_w, bl_w, ov_w, LAT_W, e_bcd, e_bl, e_ov);
         end
      end
   endtask

   task automatic test_no_blank();
      logic [9:0]  vals [3] = '{10'd7, 10'd0, 10'd1000};
      logic [19:0] e_bcd;
      logic [4:0]  e_bl;
      bit          e_ov;
      foreach (vals[i]) begin
         model(longint'(vals[i]), 3, 1'b0, e_bcd, e_bl, e_ov);
         @(negedge clk);
         en_n = 1'b1; nf_n = 1'b1; val_n = vals[i];
         @(negedge clk);
         nf_n = 1'b0;
         repeat (14) @(negedge clk);
         checks++;
         if ({ex_n, bl_n, ov_n} !== {e_bcd[11:0], e_bl[2:0], e_ov}) begin
            errors++;
            $display("FAIL no_blank v=%0d: got %h/%b/%b, want %h/%b/%b",
                     vals[i], ex_n, bl_n, ov_n, e_bcd[11:0], e_bl[2:0], e_ov);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      en_a = 1'b0; nf_a = 1'b0; val_a = '0;
      en_w = 1'b0; nf_w = 1'b0; val_w = '0;
      en_n = 1'b0; nf_n = 1'b0; val_n = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_ignore_busy();
      test_enable_low();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      test_no_blank();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter (shift-and-add-3) for on-screen numeric fields in the menu overlay.
- Captures a binary value on a frame strobe and converts it over IN_W cycles.
- Presents DIGITS registered BCD digits with a leading-zero blank mask and an overflow flag to the character ROM address logic.
- Replaces per-frame combinational divide/modulo with a small sequential datapath.

Parameters:
IN_W, 10, width of binary input (>=1)
DIGITS, 3, number of BCD output digits (>=1)
BLANK_LZ, 1, 1 = generate leading-zero blank mask; 0 = digit_blank forced to all zeros

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  conversion enable; newframe ignored while low
newframe  in  1  start strobe, synchronous to clk, sampled each clk edge
some_value  in  IN_W  unsigned binary value, sampled on accepted start
exit_value  out  4*DIGITS  BCD result, digit i at [4i+3:4i], digit 0 = units
digit_blank  out  DIGITS  bit i = 1: digit i is a leading zero, render as blank
overflow  out  1  last converted value >= 10^DIGITS
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (async, immediate): state IDLE; exit_value=0, overflow=0, busy=0, done=0.
- Reset value of digit_blank: all bits above bit 0 set when BLANK_LZ=1, else all zeros.
- Reset clears internal shift register, BCD scratch register, bit counter and sticky bit.
- Reset mid-conversion aborts it; outputs go to reset values and no done pulse is produced.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On edge with en=1 and newframe=1: capture some_value, clear scratch and sticky, load counter=IN_W, busy=1, go SHIFT.
  - Otherwise hold.
- SHIFT (one edge per input bit, MSB first):
  - Each scratch digit >=5 gets +3 (4-bit add, no carry between digits).
  - Then {sticky-source, scratch, shiftreg} shifts left by 1.
  - sticky |= bit shifted out of the top digit.
  - Counter decrements; after the IN_W-th shift go FINISH.
- FINISH (single edge):
  - overflow = sticky.
  - exit_value = scratch, or all digits 9 (saturate) if sticky.
  - digit_blank updated.
  - done=1 for exactly this cycle, busy=0, go IDLE.
- Latency: start accepted at edge E0; outputs and done valid after edge E(IN_W+1); busy high from after E0 until after E(IN_W+1).
- Back-to-back: a start coincident with done is accepted only on the following edge (FINISH→IDLE costs no extra cycle; IDLE samples next edge). Minimum period IN_W+2 cycles.
- newframe while busy: ignored, not queued.
- some_value changes during conversion: no effect.
- en deasserted during conversion: conversion completes normally; en gates only start acceptance.
- Outputs hold last result between conversions.
- digit_blank[i]=1 iff BLANK_LZ=1, i>0, and digits i..DIGITS-1 are all zero.
  - digit 0 never blanked.
  - On overflow, no digit blanked.
- IN_W < 4*DIGITS: no overflow possible when 2^IN_W <= 10^DIGITS; logic must still be legal.

Test Plan:
- Default params: some_value=0, start -> done after 11 edges; exit_value=12'h000, digit_blank=3'b110, overflow=0.
- some_value=255 -> exit_value=12'h255, digit_blank=3'b000; busy high exactly 11 cycles; done high exactly 1 cycle.
- some_value=7 -> 12'h007, blank 3'b110; some_value=40 -> 12'h040, blank 3'b100; some_value=999 -> 12'h999, overflow=0.
- some_value=1000 and 1023 -> overflow=1, exit_value=12'h999, digit_blank=0. Then value 5 -> overflow clears, 12'h005.
- Start with 123, pulse newframe at cycles 3 and 10 with a different value -> single result 12'h123. Start with en=0 -> no busy, outputs unchanged.
- Assert rst at cycle 5 of a conversion -> outputs immediately at reset values, no done. IN_W=16, DIGITS=5, value 65535 -> 20'h65535 after 17 edges. BLANK_LZ=0, value 7 -> blank 0.
